// File: rtl/hdlverifier_jtag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdlverifier_jtag_pkg: shared types/constants for the JTAG DR shifter.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hdlverifier_jtag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_LOOP   = 3'd5
  } state_t;

  localparam int HDR_BITS = 8;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_LOOP  = 8'h03;
  localparam logic [7:0] CMD_CLEAR = 8'h04;

  localparam int STAT_RD_VALID    = 7;
  localparam int STAT_WR_READY    = 6;
  localparam int STAT_OVERFLOW    = 5;
  localparam int STAT_UNDERFLOW   = 4;
  localparam int STAT_VERSION_LSB = 0;

  function automatic logic [HDR_BITS-1:0] status_byte(
    input logic       rd_valid,
    input logic       wr_ready,
    input logic       overflow,
    input logic       underflow,
    input logic [3:0] version
  );
    logic [HDR_BITS-1:0] s;
    s                          = '0;
    s[STAT_RD_VALID]           = rd_valid;
    s[STAT_WR_READY]           = wr_ready;
    s[STAT_OVERFLOW]           = overflow;
    s[STAT_UNDERFLOW]          = underflow;
    s[STAT_VERSION_LSB +: 4]   = version;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdlverifier_jtag_sipo_piso.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdlverifier_jtag_sipo_piso: paired serial-in / serial-out shift registers |
// | with parallel load and a wrapping bit counter.  Revision: 1.0            |
// +--------------------------------------------------------------------------+
module hdlverifier_jtag_sipo_piso
  import hdlverifier_jtag_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_shift_en,
  input  logic                  i_si,
  input  logic                  i_out_si,
  input  logic                  i_load_en,
  input  logic [DATA_WIDTH-1:0] i_load_val,
  input  logic                  i_cnt_clr,
  input  logic [CNT_W-1:0]      i_cnt_last,
  output logic [DATA_WIDTH-2:0] o_in_sr,
  output logic                  o_so,
  output logic [CNT_W-1:0]      o_bit_cnt
);

  // The in-shifter holds one bit less than a word: the live tdi completes it.
  logic [DATA_WIDTH-2:0] r_in_sr;
  logic [DATA_WIDTH-1:0] r_out_sr;
  logic [CNT_W-1:0]      r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_sr   <= '0;
      r_out_sr  <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (i_shift_en)
        r_in_sr <= {i_si, r_in_sr[DATA_WIDTH-2:1]};
      if (i_load_en)
        r_out_sr <= i_load_val;
      else if (i_shift_en)
        r_out_sr <= {i_out_si, r_out_sr[DATA_WIDTH-1:1]};
      if (i_cnt_clr)
        r_bit_cnt <= '0;
      else if (i_shift_en)
        r_bit_cnt <= (r_bit_cnt == i_cnt_last) ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

  assign o_in_sr   = r_in_sr;
  assign o_so      = r_out_sr[0];
  assign o_bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire

// File: rtl/hdlverifier_jtag_dr_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdlverifier_jtag_dr_shifter: JTAG user DR <-> valid/ready word streams.   |
// | Optional link loopback: define HDLV_JTAG_DR_LOOPBACK_EN.  Revision: 1.0   |
// +--------------------------------------------------------------------------+
module hdlverifier_jtag_dr_shifter
  import hdlverifier_jtag_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] VERSION    = 4'h1
) (
  input  logic                  tck,
  input  logic                  jtag_reset_n,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              CNT_W       = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_hdr_last  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] c_word_last = CNT_W'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cmd;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_valid;
  logic                  r_rd_ready;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_shift_en;
  logic                  w_out_si;
  logic                  w_load_en;
  logic [DATA_WIDTH-1:0] w_load_val;
  logic                  w_cnt_clr;
  logic [CNT_W-1:0]      w_cnt_last;
  logic                  w_cmd_ld;
  logic                  w_wr_end;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic                  w_rd_take;
  logic                  w_flag_clr;
  logic [DATA_WIDTH-2:0] w_in_sr;
  logic [CNT_W-1:0]      w_bit_cnt;
  logic                  w_so;
  logic                  w_last;
  logic [7:0]            w_hdr;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_cnt_last = (r_state == ST_HEADER) ? c_hdr_last : c_word_last;
  assign w_last     = (w_bit_cnt == w_cnt_last);
  assign w_hdr      = {tdi, w_in_sr[DATA_WIDTH-2 -: HDR_BITS-1]};
  assign w_wr_word  = {tdi, w_in_sr};
  assign w_rd_word  = rd_valid ? rd_data : '0;

`ifdef HDLV_JTAG_DR_LOOPBACK_EN
  // 8-bit pre-delay chained into the DATA_WIDTH-deep out-shifter gives DATA_WIDTH+8.
  logic [HDR_BITS-1:0] r_loop_sr;

  always_ff @(posedge tck or negedge jtag_reset_n) begin
    if (!jtag_reset_n)
      r_loop_sr <= '0;
    else if (w_shift_en && (r_state == ST_LOOP))
      r_loop_sr <= {tdi, r_loop_sr[HDR_BITS-1:1]};
  end

  assign w_out_si = (r_state == ST_LOOP) ? r_loop_sr[0] : 1'b0;
`else
  assign w_out_si = 1'b0;
`endif

  always_ff @(posedge tck or negedge jtag_reset_n) begin
    if (!jtag_reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_load_en   = 1'b0;
    w_load_val  = '0;
    w_cnt_clr   = 1'b0;
    w_cmd_ld    = 1'b0;
    w_wr_end    = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    w_rd_take   = 1'b0;
    w_flag_clr  = 1'b0;
    if (capture_dr) begin
      w_state_nxt = ST_HEADER;
      w_cnt_clr   = 1'b1;
      w_load_en   = 1'b1;
      w_load_val  = DATA_WIDTH'(status_byte(rd_valid, wr_ready, r_overflow,
                                            r_underflow, VERSION));
    end else if (update_dr) begin
      w_state_nxt = ST_IDLE;
      w_flag_clr  = (r_state == ST_DRAIN) && (r_cmd == CMD_CLEAR);
    end else if (shift_dr) begin
      case (r_state)
        ST_HEADER: begin
          w_shift_en = 1'b1;
          if (w_last) begin
            w_cmd_ld  = 1'b1;
            w_load_en = 1'b1;
            case (w_hdr)
              CMD_WRITE: w_state_nxt = ST_WRITE;
              CMD_READ: begin
                w_state_nxt = ST_READ;
                w_load_val  = w_rd_word;
                w_rd_take   = rd_valid;
                w_unf_set   = ~rd_valid;
              end
`ifdef HDLV_JTAG_DR_LOOPBACK_EN
              CMD_LOOP:  w_state_nxt = ST_LOOP;
`endif
              default:   w_state_nxt = ST_DRAIN;
            endcase
          end
        end
        ST_WRITE: begin
          w_shift_en = 1'b1;
          if (w_last) begin
            w_wr_end  = 1'b1;
            w_ovf_set = ~wr_ready;
          end
        end
        ST_READ: begin
          w_shift_en = 1'b1;
          if (w_last) begin
            w_load_en  = 1'b1;
            w_load_val = w_rd_word;
            w_rd_take  = rd_valid;
            w_unf_set  = ~rd_valid;
          end
        end
        ST_DRAIN: w_shift_en = 1'b1;
`ifdef HDLV_JTAG_DR_LOOPBACK_EN
        ST_LOOP:  w_shift_en = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // A set in the same cycle as a pending clear wins.
  always_ff @(posedge tck or negedge jtag_reset_n) begin
    if (!jtag_reset_n) begin
      r_cmd       <= '0;
      r_wr_data   <= '0;
      r_wr_valid  <= 1'b0;
      r_rd_ready  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_cmd_ld)
        r_cmd <= w_hdr;
      if (w_wr_end)
        r_wr_data <= w_wr_word;
      r_wr_valid  <= w_wr_end & wr_ready;
      r_rd_ready  <= w_rd_take;
      r_overflow  <= w_ovf_set | (r_overflow & ~w_flag_clr);
      r_underflow <= w_unf_set | (r_underflow & ~w_flag_clr);
    end
  end

  hdlverifier_jtag_sipo_piso #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_sr (
    .clk        (tck),
    .rst_n      (jtag_reset_n),
    .i_shift_en (w_shift_en),
    .i_si       (tdi),
    .i_out_si   (w_out_si),
    .i_load_en  (w_load_en),
    .i_load_val (w_load_val),
    .i_cnt_clr  (w_cnt_clr),
    .i_cnt_last (w_cnt_last),
    .o_in_sr    (w_in_sr),
    .o_so       (w_so),
    .o_bit_cnt  (w_bit_cnt)
  );

  assign tdo       = w_so;
  assign wr_data   = r_wr_data;
  assign wr_valid  = r_wr_valid;
  assign rd_ready  = r_rd_ready;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire
